// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: port geometry,
// the discarded zero register, scoreboard counter width and requester IDs.
package regfile_write_arbiter_pkg;
  localparam int RF_WIDTH    = 64;
  localparam int RF_ADDR     = 5;
  localparam int RF_ZERO_REG = 31;
  localparam int RF_CNT_W    = 2;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
endpackage

// File: rtl/pending_counter.sv
// Saturating up/down count of outstanding writes to one register.
// A simultaneous inc and dec cancel; dec at zero and inc at full are dropped.
module pending_counter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int CNT_W = RF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic full
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && busy) begin
      count <= count - CNT_W'(1);
    end
  end

  assign busy = (count != '0);
  assign full = &count;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a
// registered write stage and a per-register pending-write scoreboard.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int ADDR     = RF_ADDR,
  parameter int ZERO_REG = RF_ZERO_REG,
  parameter int CNT_W    = RF_CNT_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [ADDR-1:0]        req_addr0,
  input  logic [ADDR-1:0]        req_addr1,
  input  logic [WIDTH-1:0]       req_data0,
  input  logic [WIDTH-1:0]       req_data1,
  input  logic                   rsv_valid,
  input  logic [ADDR-1:0]        rsv_addr,
  output logic                   rsv_ready,
  output logic [(1<<ADDR)-1:0]   busy,
  output logic                   rf_W,
  output logic [ADDR-1:0]        rf_DA,
  output logic [WIDTH-1:0]       rf_D
);
  localparam int NREG = 1 << ADDR;

  // Handshake: a transfer happens on a cycle where valid & ready are both 1;
  // valid must not depend on ready, and ready never depends on rf_* outputs.
  logic              last_grant;
  logic [1:0]        xfer;
  logic              xfer_any;
  logic              xfer_id;
  logic [ADDR-1:0]   sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic [NREG-1:0]   full;

  always_comb begin
    req_ready = 2'b00;
    if (!reset) begin
      if (req_valid[REQ_ALU] && req_valid[REQ_LOAD]) begin
        req_ready = (last_grant == 1'(REQ_LOAD)) ? 2'b01 : 2'b10;
      end else begin
        req_ready = req_valid;
      end
    end
  end

  assign xfer     = req_valid & req_ready;
  assign xfer_any = |xfer;
  assign xfer_id  = xfer[REQ_LOAD];
  assign sel_addr = xfer_id ? req_addr1 : req_addr0;
  assign sel_data = xfer_id ? req_data1 : req_data0;

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_W       <= 1'b0;
      rf_DA      <= '0;
      rf_D       <= '0;
      last_grant <= 1'(REQ_LOAD);
    end else begin
      rf_W <= xfer_any && (sel_addr != ADDR'(ZERO_REG));
      if (xfer_any) begin
        rf_DA      <= sel_addr;
        rf_D       <= sel_data;
        last_grant <= xfer_id;
      end
    end
  end

  assign rsv_ready = (rsv_addr == ADDR'(ZERO_REG)) || !full[rsv_addr];

  // The commit decrement lands on the same edge the register file captures.
  for (genvar i = 0; i < NREG; i++) begin : g_cnt
    logic inc;
    logic dec;
    if (i == ZERO_REG) begin : g_zero
      assign inc = 1'b0;
      assign dec = 1'b0;
    end else begin : g_live
      assign inc = rsv_valid && rsv_ready && (rsv_addr == ADDR'(i));
      assign dec = rf_W && (rf_DA == ADDR'(i));
    end
    pending_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (inc),
      .dec   (dec),
      .busy  (busy[i]),
      .full  (full[i])
    );
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a behavioural model of grants,
// write stage and pending counts is checked against the DUT every cycle.
module tb_regfile_write_arbiter;
  localparam int W  = 64;
  localparam int A  = 5;
  localparam int NR = 32;
  localparam int ZR = 31;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [A-1:0]  req_addr0 = '0;
  logic [A-1:0]  req_addr1 = '0;
  logic [W-1:0]  req_data0 = '0;
  logic [W-1:0]  req_data1 = '0;
  logic          rsv_valid = 1'b0;
  logic [A-1:0]  rsv_addr = '0;
  logic          rsv_ready;
  logic [NR-1:0] busy;
  logic          rf_W;
  logic [A-1:0]  rf_DA;
  logic [W-1:0]  rf_D;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  regfile_write_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .busy      (busy),
    .rf_W      (rf_W),
    .rf_DA     (rf_DA),
    .rf_D      (rf_D)
  );

  // clock / reset
  always #5 clock = ~clock;

  // behavioural model state
  int           m_cnt [NR];
  bit           m_last;
  logic         m_w;
  logic [A-1:0] m_da;
  logic [W-1:0] m_d;

  function automatic logic [1:0] exp_ready();
    if (reset) return 2'b00;
    if (req_valid == 2'b11) return m_last ? 2'b01 : 2'b10;
    return req_valid;
  endfunction

  function automatic logic exp_rsv();
    return (int'(rsv_addr) == ZR) || (m_cnt[rsv_addr] < 3);
  endfunction

  function automatic logic [NR-1:0] exp_busy();
    logic [NR-1:0] b;
    b = '0;
    for (int i = 0; i < NR; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clock) begin
    logic [1:0] g;
    int net [NR];
    int nv;
    if (reset) begin
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      m_last = 1'b1;
      m_w    = 1'b0;
      m_da   = '0;
      m_d    = '0;
    end else begin
      g = exp_ready() & req_valid;
      for (int i = 0; i < NR; i++) net[i] = 0;
      if (m_w && int'(m_da) != ZR) net[m_da] = net[m_da] - 1;
      if (rsv_valid && exp_rsv() && int'(rsv_addr) != ZR) net[rsv_addr] = net[rsv_addr] + 1;
      for (int i = 0; i < NR; i++) begin
        nv = m_cnt[i] + net[i];
        m_cnt[i] = (nv < 0) ? 0 : nv;
      end
      if (g != 2'b00) begin
        m_last = g[1];
        m_da   = g[1] ? req_addr1 : req_addr0;
        m_d    = g[1] ? req_data1 : req_data0;
        m_w    = (int'(m_da) != ZR);
      end else begin
        m_w = 1'b0;
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clock) begin
    if (chk_en) begin
      check("req_ready", 64'(req_ready), 64'(exp_ready()));
      check("rsv_ready", 64'(rsv_ready), 64'(exp_rsv()));
      check("busy",      64'(busy),      64'(exp_busy()));
      check("rf_W",      64'(rf_W),      64'(m_w));
      check("rf_DA",     64'(rf_DA),     64'(m_da));
      check("rf_D",      rf_D,           m_d);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req_valid = 2'b00;
    rsv_valid = 1'b0;
  endtask

  task automatic write0(input int addr, input logic [W-1:0] data);
    req_valid = 2'b01;
    req_addr0 = A'(addr);
    req_data0 = data;
  endtask

  initial begin
    logic [1:0] e_rdy;
    tick();
    tick();
    chk_en = 1'b1;
    reset  = 1'b0;
    #1;
    check("rst_rf_W", 64'(rf_W), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // single write X5
    write0(5, 64'h1234);
    #1;
    check("x5_ready", 64'(req_ready), 64'd1);
    tick();
    idle();
    check("x5_W",  64'(rf_W),  64'd1);
    check("x5_DA", 64'(rf_DA), 64'd5);
    check("x5_D",  rf_D,       64'h1234);
    check("x5_busy", 64'(busy), 64'd0);
    tick();
    check("x5_W_off", 64'(rf_W), 64'd0);

    // lone requester 1, then contention alternates starting with 0
    req_valid = 2'b10; req_addr1 = 5'd3; req_data1 = 64'h33;
    #1;
    check("lone1_ready", 64'(req_ready), 64'd2);
    tick();
    for (int k = 0; k < 4; k++) begin
      req_valid = 2'b11;
      req_addr0 = 5'd1; req_data0 = 64'h100 + 64'(k);
      req_addr1 = 5'd2; req_data1 = 64'h200 + 64'(k);
      e_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check("rr_ready", 64'(req_ready), 64'(e_rdy));
      tick();
      check("rr_DA", 64'(rf_DA), (k % 2 == 0) ? 64'd1 : 64'd2);
      check("rr_D",  rf_D, (k % 2 == 0) ? 64'h100 + 64'(k) : 64'h200 + 64'(k));
    end
    idle();
    tick();

    // saturate X7, then drain with three commits
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("x7_rsv_ok", 64'(rsv_ready), 64'd1);
      tick();
    end
    #1;
    check("x7_rsv_full", 64'(rsv_ready), 64'd0);
    check("x7_busy", 64'(busy[7]), 64'd1);
    tick();
    rsv_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      write0(7, 64'h70 + 64'(k));
      tick();
    end
    idle();
    check("x7_last_W", 64'(rf_W), 64'd1);
    check("x7_busy_staged", 64'(busy[7]), 64'd1);
    tick();
    check("x7_busy_clear", 64'(busy[7]), 64'd0);

    // X9: reserve and commit on the same edge with count 1
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    tick();
    rsv_valid = 1'b0;
    write0(9, 64'h99);
    tick();
    idle();
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    check("x9_W", 64'(rf_W), 64'd1);
    tick();
    rsv_valid = 1'b0;
    check("x9_hold", 64'(busy[9]), 64'd1);
    write0(9, 64'h9a);
    tick();
    idle();
    tick();
    tick();
    check("x9_drain", 64'(busy[9]), 64'd0);

    // X31 write and reserve are discarded
    req_valid = 2'b10; req_addr1 = 5'd31; req_data1 = 64'hdead;
    rsv_valid = 1'b1;  rsv_addr = 5'd31;
    #1;
    check("x31_rsv", 64'(rsv_ready), 64'd1);
    tick();
    idle();
    check("x31_W", 64'(rf_W), 64'd0);
    check("x31_busy", 64'(busy[31]), 64'd0);
    tick();

    // reset while a write is staged
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    tick();
    rsv_valid = 1'b0;
    write0(4, 64'h44);
    tick();
    req_valid = 2'b11;
    reset = 1'b1;
    check("pre_rst_W", 64'(rf_W), 64'd1);
    check("pre_rst_busy4", 64'(busy[4]), 64'd1);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    tick();
    check("post_rst_W", 64'(rf_W), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    req_addr0 = 5'd10; req_addr1 = 5'd11;
    #1;
    check("post_rst_grant", 64'(req_ready), 64'd1);
    tick();

    // mixed traffic checked by the model
    for (int k = 0; k < 16; k++) begin
      req_valid = 2'(k & 3);
      req_addr0 = A'(k % 8);       req_data0 = 64'hA000 + 64'(k);
      req_addr1 = A'((k * 3) % 32); req_data1 = 64'hB000 + 64'(k);
      rsv_valid = ((k & 1) != 0);
      rsv_addr  = A'(12 + k % 4);
      tick();
    end
    idle();
    for (int k = 0; k < 6; k++) tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port (W, DA, D) of the 32x64 ARMv8 register file between two writeback requesters: requester 0 is ALU writeback and requester 1 is load writeback. Grants use round-robin priority and drive the write port from a registered stage. A per-register pending-write scoreboard exposes a busy vector, which issue logic uses to stall reads of registers with writes still outstanding. Writes to X31 (XZR) are accepted and discarded.

## Interface
Parameters:
- WIDTH, 64, data width of register file entries
- ADDR, 5, register address width (32 registers)
- ZERO_REG, 31, register index whose writes are discarded and which is never busy
- CNT_W, 2, width of per-register pending counter (max 3 outstanding writes per register)

Ports:
- clock  in  1  positive-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-requester write request valid
- req_ready  out  2  per-requester grant (combinational)
- req_addr0, req_addr1  in  ADDR  destination register per requester
- req_data0, req_data1  in  WIDTH  write data per requester
- rsv_valid  in  1  issue stage reserves a destination register
- rsv_addr  in  ADDR  register being reserved
- rsv_ready  out  1  reservation accepted (combinational)
- busy  out  32  bit i set while register i has pending writes
- rf_W  out  1  register file write enable (registered)
- rf_DA  out  ADDR  register file destination address (registered)
- rf_D  out  WIDTH  register file write data (registered)

## Operation
- **Arbitration**
  - One write is accepted per cycle.
  - A transfer occurs on a requester when req_valid[i] & req_ready[i].
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted; last_grant updates only on a transfer.
  - req_ready is 0 while reset is asserted and 0 for a requester that is not valid.
- **Write stage**
  - A transfer loads rf_DA and rf_D and sets rf_W = 1, unless the address is ZERO_REG, in which case rf_W = 0.
  - With no transfer, rf_W = 0; rf_DA and rf_D hold their values.
- **Scoreboard**
  - Each register i has a CNT_W-bit pending counter; busy[i] = (count != 0).
  - An accepted reservation (rsv_valid & rsv_ready) increments the counter.
  - A committed write increments nothing and decrements the counter on the clock edge where rf_W = 1 for that register.
  - An increment and a decrement of the same register in the same cycle leave the counter unchanged.
  - rsv_ready = 0 when the target counter = 3 (saturated); rsv_ready is always 1 for ZERO_REG.
  - Reservations and commits to ZERO_REG are ignored, so busy[ZERO_REG] = 0 always.
  - A commit to a register whose counter = 0 leaves the counter at 0 (no underflow). The write still occurs.
- **Reset**
  - rf_W = 0, rf_DA = 0, rf_D = 0.
  - All counters = 0, so busy = 0.
  - last_grant = 1, so requester 0 wins the first contention.
  - Reset asserted mid-operation drops any staged write: rf_W = 0 on the cycle after reset.

## Timing
- A transfer in cycle N presents rf_W/rf_DA/rf_D in cycle N+1. The register file captures at the end of N+1.
- busy[a] clears at the end of cycle N+1, the same edge the register file captures, so a read issued in N+2 sees the new data.
- A reservation in cycle N sets busy in cycle N+1.
- req_ready and rsv_ready depend combinationally on the valid inputs and current state. There are no combinational paths from the rf_* outputs.
- Throughput: 1 write per cycle sustained. With both requesters continuously valid, grants alternate 0,1,0,1.

## Structure
- Shared package/include holds WIDTH, ADDR, ZERO_REG, CNT_W and requester-ID constants (REQ_ALU = 0, REQ_LOAD = 1).
- One sub-module, `pending_counter`: a CNT_W-bit saturating up/down counter with inc, dec, sync reset, busy and full outputs. It is instantiated 32 times (the ZERO_REG instance is tied off).
- The top level contains the round-robin grant logic, the write-stage register and the scoreboard array.

## Test plan
- Reset, then requester 0 writes X5 = 0x1234 -> rf_W = 1, rf_DA = 5, rf_D = 0x1234 exactly one cycle later; busy = 0 throughout.
- Both requesters valid for 4 cycles (X1/X2) -> grants 0,1,0,1; rf_DA sequence 1,2,1,2; each loser sees req_ready = 0.
- Reserve X7 three times -> rsv_ready drops on a fourth attempt; three commits to X7 -> busy[7] clears after the third, one cycle after that commit's rf_W.
- Reserve X9 and commit X9 in the same cycle with count = 1 -> count stays 1 and busy[9] stays set.
- Write and reserve X31 -> rf_W = 0, rsv_ready = 1, busy[31] = 0.
- Transfer accepted, reset asserted the next cycle -> rf_W = 0 and busy = 0 after reset; the first contention after reset grants requester 0.
